// File: rtl/btn_pkg.sv
// Shared definitions for the button front end: channel FSM encoding,
// channel index constants and channel count.
package btn_pkg;

  localparam int unsigned NUM_BTN = 3;

  // Channel indices on the command bus
  localparam int unsigned BTN_RST = 0;
  localparam int unsigned BTN_UP  = 1;
  localparam int unsigned BTN_DN  = 2;

  // Per-channel debounce FSM states
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchronizer, counter-based debounce FSM,
// press one-shot and (with BTN_AUTOREPEAT_EN defined) hold/auto-repeat.
// Ports:
//   i_clk       system clock
//   i_reset     synchronous active-high reset
//   i_btn_raw   asynchronous raw button pin, active-high
//   o_level     debounced level, registered
//   o_event_c   combinational event strobe: high in the cycle before the
//               debounced press edge registers, and on each repeat tick
// Optional: BTN_AUTOREPEAT_EN enables the repeat counter when REPEAT_EN=1.
module button_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_event_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  // Reject illegal parameterisations at elaboration
  if (DEBOUNCE_CYCLES < 4 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("button_debounce: illegal DEBOUNCE/HOLD/REPEAT parameters");
  end

  logic [1:0]       r_sync;
  logic             w_s;
  btn_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, w_level_nxt;
  logic             w_press_event;
  logic             w_rep_event;
  logic             w_cnt_last;

  assign w_s        = r_sync[1];
  assign w_cnt_last = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Synchronizer, state, counter and level registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync  <= 2'b00;
      r_state <= ST_RELEASED;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_raw};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  // Next-state, counter and level logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_event = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        if (w_s) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = '0;
        end else if (w_cnt_last) begin
          w_state_nxt   = ST_PRESSED;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b1;
          w_press_event = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (w_cnt_last) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;

  if (REPEAT_EN) begin : g_repeat
    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_phase;
    logic             w_rep_hit;

    // Phase 0 waits out the initial hold, phase 1 ticks at the repeat period
    assign w_rep_hit = r_rep_phase ? (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1))
                                   : (r_rep_cnt == REP_W'(HOLD_CYCLES - 1));

    always_ff @(posedge i_clk) begin
      if (i_reset || (r_state != ST_PRESSED)) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_rep_hit) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + REP_W'(1);
      end
    end

    assign w_rep_event = (r_state == ST_PRESSED) && w_rep_hit;
  end else begin : g_no_repeat
    assign w_rep_event = 1'b0;
  end
`else
  assign w_rep_event = 1'b0 & REPEAT_EN;
`endif

  assign o_level   = r_level;
  assign o_event_c = w_press_event | w_rep_event;

endmodule

// File: rtl/button_pulse_gen.sv
// Button front end: three debounced channels feeding a pending buffer and a
// fixed-priority arbiter that emits one-cycle, at-most-one-hot command pulses.
// Ports:
//   i_clk       system clock
//   i_reset     synchronous active-high reset
//   i_btn_raw   [2:0] raw button pins (0=reset-to-0, 1=up, 2=down)
//   o_button    [2:0] single-cycle command pulses, registered, never multi-hot
//   o_level     [2:0] debounced button levels, registered
// Optional: BTN_AUTOREPEAT_EN adds hold/auto-repeat on the up/down channels.
module button_pulse_gen
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  output logic [NUM_BTN-1:0] o_button,
  output logic [NUM_BTN-1:0] o_level
);

  logic [NUM_BTN-1:0] w_event;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_req;
  logic [NUM_BTN-1:0] w_grant;
  logic [NUM_BTN-1:0] w_pending_nxt;
  logic [NUM_BTN-1:0] r_pending;
  logic [NUM_BTN-1:0] r_button;

  // Per-channel conditioning; only up/down may auto-repeat
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       ((gi != BTN_RST) && ((gi == BTN_UP) || (gi == BTN_DN)))
    ) u_debounce (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_btn_raw (i_btn_raw[gi]),
      .o_level   (w_level[gi]),
      .o_event_c (w_event[gi])
    );
  end

  // Fresh events join the request set directly so an uncontended press is
  // emitted on the same edge its level rises.
  assign w_req   = r_pending | w_event;
  assign w_grant = w_req & (~w_req + NUM_BTN'(1));

  // A new event on a bit whose earlier request is being granted stays pending
  assign w_pending_nxt = (w_req & ~w_grant) | (r_pending & w_event);

  // Pending buffer and registered command output
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending <= '0;
      r_button  <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_button  <= w_grant;
    end
  end

  assign o_button = r_button;
  assign o_level  = w_level;

endmodule
